// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : 5-stage pipeline hazard unit: data-memory stall/timeout, branch
//            flush and load-use bubble. Optional perf counters: HAZARD_PERF_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_write_reg_addr,
   input  logic        m_branch,
   input  logic        m_alu_zero,
   input  logic        m_mem_read,
   input  logic        m_mem_write,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        fd_write,
   output logic        dx_write,
   output logic        xm_write,
   output logic        fd_flush,
   output logic        dx_flush,
   output logic        xm_flush,
   output logic        mw_flush,
   output logic        pc_src,
   output logic        mem_req,
`ifdef HAZARD_PERF_CNT_EN
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count,
`endif
   output logic        mem_error
);

   localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_ERR  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_next_cnt;
   logic       w_mem_access;
   logic       w_branch_taken;
   logic       w_load_use;

   assign w_mem_access   = m_mem_read | m_mem_write;
   assign w_branch_taken = m_branch & m_alu_zero;
   assign w_load_use     = ex_mem_read && (ex_write_reg_addr != 5'd0) &&
                           ((ex_write_reg_addr == id_rs_addr) ||
                            (id_uses_rt && (ex_write_reg_addr == id_rt_addr)));

   always_comb begin
      pc_write     = 1'b1;
      fd_write     = 1'b1;
      dx_write     = 1'b1;
      xm_write     = 1'b1;
      fd_flush     = 1'b0;
      dx_flush     = 1'b0;
      xm_flush     = 1'b0;
      mw_flush     = 1'b0;
      pc_src       = 1'b0;
      mem_req      = 1'b0;
      mem_error    = 1'b0;
      w_next_state = r_state;
      w_next_cnt   = r_wait_cnt;
      if (!reset) begin
         case (r_state)
            RUN: begin
               mem_req = w_mem_access;
               if (w_mem_access && !mem_ready) begin
                  {pc_write, fd_write, dx_write, xm_write} = 4'b0000;
                  mw_flush     = 1'b1;
                  w_next_state = MEM_WAIT;
                  w_next_cnt   = 8'd1;
               end else if (w_branch_taken) begin
                  pc_src   = 1'b1;
                  fd_flush = 1'b1;
                  dx_flush = 1'b1;
                  xm_flush = 1'b1;
               end else if (w_load_use) begin
                  // Hold PC/IF-ID and inject one bubble into ID/EX.
                  pc_write = 1'b0;
                  fd_write = 1'b0;
                  dx_flush = 1'b1;
               end
            end
            MEM_WAIT: begin
               mem_req = 1'b1;
               if (!mem_ready) begin
                  {pc_write, fd_write, dx_write, xm_write} = 4'b0000;
                  mw_flush = 1'b1;
                  if (r_wait_cnt == c_TIMEOUT) begin
                     w_next_state = MEM_ERR;
                  end else begin
                     w_next_cnt = r_wait_cnt + 8'd1;
                  end
               end else begin
                  w_next_state = RUN;
                  w_next_cnt   = 8'd0;
               end
            end
            MEM_ERR: begin
               {pc_write, fd_write, dx_write, xm_write} = 4'b0000;
               mem_error = 1'b1;
            end
            default: begin
               w_next_state = RUN;
               w_next_cnt   = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RUN;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_cnt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= 16'd0;
         r_flush_count  <= 16'd0;
      end else begin
         if ((r_state != MEM_ERR) && !pc_write && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
         end
         if (pc_src && (r_flush_count != 16'hFFFF)) begin
            r_flush_count <= r_flush_count + 16'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire
